// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
package adc_sched_pkg;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitHi,
    StWaitLo,
    StDone
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int unsigned NReq = 4
) (
  input  logic [NReq-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NReq-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NReq; i++) begin
      j = (32'(ptr_i) + i) % NReq;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Sequences the shared serial ADC driver between NREQ requesters and a periodic timer.
// Optional busy-wait timeout is built when ADC_SCHED_TIMEOUT_EN is defined.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned PER_W   = 16,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  input  logic             per_en,
  input  logic [PER_W-1:0] per_period,
  output logic             rsp_valid,
  output logic [ADC_W-1:0] rsp_data,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_per,
  output logic             rsp_err,
  output logic             adc_en,
  input  logic             adc_busy,
  input  logic [ADC_W-1:0] adc_data,
  output logic             sched_busy
);

  if (NREQ < 1 || NREQ > 8 || TMO_CYC < 1) begin : g_param_check
    $error("adc_sample_scheduler: parameter out of range");
  end

  sched_state_e     state_q, state_d;
  logic             win_per_q, win_per_d;
  logic [ID_W-1:0]  win_idx_q, win_idx_d;
  logic [NREQ-1:0]  win_oh_q, win_oh_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PER_W-1:0] per_cnt_q;
  logic             per_pend_q;
  logic [ADC_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_per_q, rsp_per_d;
  logic             rsp_err_q, rsp_err_d;
  logic             per_clr;
  logic             tmo_hit;

  logic [NREQ-1:0]  arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_valid;

  rr_arbiter #(
    .NReq (NREQ)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign per_clr = (state_q == StDone) && win_per_q;

  // Period timer: a tick arriving while a slot is already pending is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q  <= '0;
      per_pend_q <= 1'b0;
    end else if (!per_en) begin
      per_cnt_q  <= '0;
      per_pend_q <= 1'b0;
    end else begin
      if (per_cnt_q == per_period) begin
        per_cnt_q <= '0;
      end else begin
        per_cnt_q <= per_cnt_q + 1'b1;
      end
      if (per_clr) begin
        per_pend_q <= 1'b0;
      end else if (per_cnt_q == per_period) begin
        per_pend_q <= 1'b1;
      end
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  // Counts cycles spent waiting on the driver; cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StWaitHi || state_q == StWaitLo) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt_q == TmoW'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM and response-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_per_q  <= 1'b0;
      win_idx_q  <= '0;
      win_oh_q   <= '0;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_per_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_per_q  <= win_per_d;
      win_idx_q  <= win_idx_d;
      win_oh_q   <= win_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_per_q  <= rsp_per_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state: arbitrate in idle, pulse the driver, track busy, publish on completion.
  always_comb begin
    state_d    = state_q;
    win_per_d  = win_per_q;
    win_idx_d  = win_idx_q;
    win_oh_d   = win_oh_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_per_d  = rsp_per_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (per_pend_q) begin
          win_per_d = 1'b1;
          win_idx_d = '0;
          win_oh_d  = '0;
          state_d   = StStart;
        end else if (arb_valid) begin
          win_per_d = 1'b0;
          win_idx_d = arb_idx;
          win_oh_d  = arb_gnt;
          state_d   = StStart;
        end
      end
      StStart: state_d = StWaitHi;
      StWaitHi: begin
        if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_id_d   = win_idx_q;
          rsp_per_d  = win_per_q;
          state_d    = StDone;
        end else if (adc_busy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_id_d   = win_idx_q;
          rsp_per_d  = win_per_q;
          state_d    = StDone;
        end else if (!adc_busy) begin
          rsp_data_d = adc_data;
          rsp_err_d  = 1'b0;
          rsp_id_d   = win_idx_q;
          rsp_per_d  = win_per_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!win_per_q) begin
          rr_ptr_d = (win_idx_q == ID_W'(NREQ - 1)) ? '0 : win_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign adc_en     = (state_q == StStart);
  assign rsp_valid  = (state_q == StDone);
  assign ack        = (state_q == StDone && !win_per_q) ? win_oh_q : '0;
  assign sched_busy = (state_q != StIdle);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_per    = rsp_per_q;
  assign rsp_err    = rsp_err_q;

endmodule
